onehot_count_checker: RTL and testbench

Receiving end of the one-hot counter bus: consumes the registered 8-bit one-hot position word produced by the ripple-counter/decoder stage and converts it back to a binary count. Validates every accepted sample (exactly one bit set) and tracks the sequence (each sample must be previous+1, wrapping). Reports lock status and error pulses, and keeps a saturating error count. Sits directly downstream of the counter/decoder in the sequential-exercise datapath.

---
 rtl/onehot_count_checker.sv | 118 +++++++++++
 tb/tb_onehot_count_checker.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_count_checker.sv
// One-hot to binary checker: validates one-hot samples, tracks +1 sequence, reports lock and errors.
// Build option: define ONEHOT_PRIORITY_EN to accept multi-hot words (highest set bit wins).
module onehot_count_checker #(
  parameter int N_BITS     = 3,
  parameter int LOCK_COUNT = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [2**N_BITS-1:0]   onehot_in,
  input  logic                   onehot_valid,
  output logic [N_BITS-1:0]      bin_out,
  output logic                   bin_valid,
  output logic                   locked,
  output logic                   err_invalid,
  output logic                   err_seq,
  output logic [ERR_CNT_W-1:0]   err_count
);

  localparam int W    = 2**N_BITS;
  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [MC_W-1:0] LOCK_CNT_V = MC_W'(LOCK_COUNT);
  localparam logic [MC_W:0]   LOCK_TGT   = (MC_W+1)'(LOCK_COUNT);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t            state;
  logic [N_BITS-1:0] expected;
  logic [MC_W-1:0]   match_cnt;

  logic [N_BITS:0]   ones;
  logic [N_BITS-1:0] code;
  logic              good;
  logic [MC_W:0]     match_inc;

  // Ascending scan leaves code at the highest set bit.
  always_comb begin
    ones = '0;
    code = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (onehot_in[i]) begin
        ones = ones + 1'b1;
        code = N_BITS'(i);
      end
    end
`ifdef ONEHOT_PRIORITY_EN
    good = (ones != '0);
`else
    good = (ones == (N_BITS+1)'(1));
`endif
    match_inc = {1'b0, match_cnt} + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= HUNT;
      expected    <= '0;
      match_cnt   <= '0;
      bin_out     <= '0;
      bin_valid   <= 1'b0;
      locked      <= 1'b0;
      err_invalid <= 1'b0;
      err_seq     <= 1'b0;
      err_count   <= '0;
    end else begin
      bin_valid   <= 1'b0;
      err_invalid <= 1'b0;
      err_seq     <= 1'b0;
      if (enable && onehot_valid) begin
        if (good) begin
          bin_out   <= code;
          bin_valid <= 1'b1;
          expected  <= code + 1'b1;
          case (state)
            HUNT: begin
              if (match_cnt != '0 && code == expected) begin
                if (match_inc >= LOCK_TGT) begin
                  match_cnt <= LOCK_CNT_V;
                  state     <= LOCKED;
                  locked    <= 1'b1;
                end else begin
                  match_cnt <= match_inc[MC_W-1:0];
                end
              end else begin
                match_cnt <= MC_W'(1);
                if (LOCK_COUNT == 1) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end
            end
            LOCKED: begin
              if (code != expected) begin
                err_seq   <= 1'b1;
                state     <= HUNT;
                locked    <= 1'b0;
                match_cnt <= MC_W'(1);
                if (err_count != '1) err_count <= err_count + 1'b1;
              end
            end
            default: begin
              state  <= HUNT;
              locked <= 1'b0;
            end
          endcase
        end else begin
          err_invalid <= 1'b1;
          match_cnt   <= '0;
          state       <= HUNT;
          locked      <= 1'b0;
          if (err_count != '1) err_count <= err_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_onehot_count_checker.sv
// Scoreboard bench for onehot_count_checker: a behavioural model queues expected outputs per cycle.
module tb_onehot_count_checker;
  localparam int N_BITS     = 3;
  localparam int LOCK_COUNT = 2;
  localparam int ERR_CNT_W  = 8;
  localparam int W          = 2**N_BITS;

  logic                 clock;
  logic                 reset;
  logic                 enable;
  logic [W-1:0]         onehot_in;
  logic                 onehot_valid;
  logic [N_BITS-1:0]    bin_out;
  logic                 bin_valid;
  logic                 locked;
  logic                 err_invalid;
  logic                 err_seq;
  logic [ERR_CNT_W-1:0] err_count;

  onehot_count_checker #(
    .N_BITS(N_BITS),
    .LOCK_COUNT(LOCK_COUNT),
    .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .onehot_in(onehot_in),
    .onehot_valid(onehot_valid),
    .bin_out(bin_out),
    .bin_valid(bin_valid),
    .locked(locked),
    .err_invalid(err_invalid),
    .err_seq(err_seq),
    .err_count(err_count)
  );

  typedef struct packed {
    logic [N_BITS-1:0]    bin;
    logic                 bv;
    logic                 lk;
    logic                 ei;
    logic                 es;
    logic [ERR_CNT_W-1:0] ec;
  } obs_t;

  obs_t sb[$];
  obs_t obs;
  obs_t exp;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  int m_bin = 0, m_lk = 0, m_exp = 0, m_match = 0, m_ec = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic obs_t model_step(input logic r, input logic e, input logic v,
                                      input logic [W-1:0] d);
    obs_t o;
    int   n, c;
    bit   g, found;
    o.bv = 0; o.ei = 0; o.es = 0;
    if (r) begin
      m_bin = 0; m_lk = 0; m_exp = 0; m_match = 0; m_ec = 0;
    end else if (e && v) begin
      n = $countones(d);
`ifdef ONEHOT_PRIORITY_EN
      g = (n >= 1);
`else
      g = (n == 1);
`endif
      c = 0; found = 0;
      for (int i = W-1; i >= 0; i--)
        if (!found && d[i]) begin c = i; found = 1; end
      if (g) begin
        m_bin = c;
        o.bv  = 1;
        if (m_lk != 0) begin
          if (c != m_exp) begin
            o.es = 1; m_lk = 0; m_match = 1;
            if (m_ec < 2**ERR_CNT_W - 1) m_ec++;
          end
        end else if (m_match > 0 && c == m_exp) begin
          m_match++;
          if (m_match >= LOCK_COUNT) begin m_match = LOCK_COUNT; m_lk = 1; end
        end else begin
          m_match = 1;
          if (LOCK_COUNT == 1) m_lk = 1;
        end
        m_exp = (c + 1) % W;
      end else begin
        o.ei = 1; m_match = 0; m_lk = 0;
        if (m_ec < 2**ERR_CNT_W - 1) m_ec++;
      end
    end
    o.bin = N_BITS'(m_bin);
    o.lk  = (m_lk != 0);
    o.ec  = ERR_CNT_W'(m_ec);
    return o;
  endfunction

  // Drive one cycle, queue the model's prediction, then sample #1 after the edge.
  task automatic cycle(input logic r, input logic e, input logic v, input logic [W-1:0] d);
    @(negedge clock);
    reset = r; enable = e; onehot_valid = v; onehot_in = d;
    sb.push_back(model_step(r, e, v, d));
    @(posedge clock);
    #1;
    obs = {bin_out, bin_valid, locked, err_invalid, err_seq, err_count};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      exp = sb.pop_front(); n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL reset[%0d]: observed %h required %h", i, obs, exp); end
    end
    n_cmp++;
    if (obs !== '0) begin n_err++; $display("FAIL reset_zero: observed %h required 0", obs); end
  endtask

  task automatic test_sequence();
    logic [W-1:0] pat [3] = '{8'h01, 8'h02, 8'h04};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1, pat[i]);
      exp = sb.pop_front(); n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL sequence[%0d]: observed %h required %h", i, obs, exp); end
      n_cmp++;
      if (bin_out !== N_BITS'(i) || bin_valid !== 1'b1) begin
        n_err++; $display("FAIL sequence_bin[%0d]: observed %0d/%b required %0d/1", i, bin_out, bin_valid, i);
      end
      if (i == 1) begin
        n_cmp++;
        if (locked !== 1'b1) begin n_err++; $display("FAIL lock_rise: observed %b required 1", locked); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] d;
    for (int i = 3; i <= 8; i++) begin
      d = 8'h01 << (i % W);
      cycle(1'b0, 1'b1, 1'b1, d);
      exp = sb.pop_front(); n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL wrap[%0d]: observed %h required %h", i, obs, exp); end
    end
    n_cmp++;
    if (bin_out !== '0 || locked !== 1'b1 || err_seq !== 1'b0) begin
      n_err++; $display("FAIL wrap_final: observed bin=%0d lk=%b es=%b required bin=0 lk=1 es=0", bin_out, locked, err_seq);
    end
  endtask

  task automatic test_seq_error();
    logic [W-1:0] pat [5] = '{8'h02, 8'h04, 8'h08, 8'h40, 8'h80};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b1, pat[i]);
      exp = sb.pop_front(); n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL seq_error[%0d]: observed %h required %h", i, obs, exp); end
      if (i == 3) begin
        n_cmp++;
        if (err_seq !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1) begin
          n_err++; $display("FAIL seq_error_pulse: observed es=%b lk=%b ec=%0d required es=1 lk=0 ec=1", err_seq, locked, err_count);
        end
      end
    end
    n_cmp++;
    if (locked !== 1'b1) begin n_err++; $display("FAIL relock: observed %b required 1", locked); end
  endtask

  task automatic test_invalid();
    cycle(1'b0, 1'b1, 1'b1, 8'h00);
    exp = sb.pop_front(); n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL invalid_zero: observed %h required %h", obs, exp); end
    n_cmp++;
    if (err_invalid !== 1'b1 || bin_valid !== 1'b0 || bin_out !== 3'd7) begin
      n_err++; $display("FAIL invalid_zero_fields: observed ei=%b bv=%b bin=%0d required ei=1 bv=0 bin=7", err_invalid, bin_valid, bin_out);
    end
    cycle(1'b0, 1'b1, 1'b1, 8'h03);
    exp = sb.pop_front(); n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL invalid_multi: observed %h required %h", obs, exp); end
  endtask

  task automatic test_enable_hold();
    obs_t held;
    cycle(1'b0, 1'b1, 1'b1, 8'h01);
    exp = sb.pop_front(); n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL hold_pre0: observed %h required %h", obs, exp); end
    cycle(1'b0, 1'b1, 1'b1, 8'h02);
    exp = sb.pop_front(); n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL hold_pre1: observed %h required %h", obs, exp); end
    held = obs;
    held.bv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b1, W'($urandom));
      exp = sb.pop_front(); n_cmp++;
      if (obs !== exp || obs !== held) begin
        n_err++; $display("FAIL hold[%0d]: observed %h required %h", i, obs, held);
      end
    end
    cycle(1'b0, 1'b1, 1'b1, 8'h04);
    exp = sb.pop_front(); n_cmp++;
    if (obs !== exp || bin_out !== 3'd2 || locked !== 1'b1 || err_seq !== 1'b0) begin
      n_err++; $display("FAIL hold_resume: observed %h required %h", obs, exp);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0, 1: d = W'(1) << ((m_exp + ($urandom_range(0, 7) == 0 ? 3 : 0)) % W);
        2:    d = W'(1) << $urandom_range(0, W-1);
        default: d = W'($urandom);
      endcase
      cycle(1'b0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0), d);
      exp = sb.pop_front(); n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL random[%0d]: observed %h required %h", i, obs, exp); end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 8'h00);
      exp = sb.pop_front(); n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL saturate[%0d]: observed %h required %h", i, obs, exp); end
    end
    n_cmp++;
    if (err_count !== 8'd255) begin n_err++; $display("FAIL saturate_final: observed %0d required 255", err_count); end
    cycle(1'b1, 1'b1, 1'b1, 8'h00);
    exp = sb.pop_front(); n_cmp++;
    if (obs !== exp || obs !== '0) begin
      n_err++; $display("FAIL reset_mid: observed %h required 0", obs);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; onehot_valid = 1'b0; onehot_in = '0;
    test_reset();
    test_sequence();
    test_wrap();
    test_seq_error();
    test_invalid();
    test_enable_hold();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
